add_serial_sched: RTL and testbench

Round-robin scheduler that shares one `add_serial` instance between `NREQ` requesters. It latches the winning requester's operands and drives the adder's `en`/`a`/`b`. It waits the adder's fixed latency, captures `out`, returns a per-requester `done` pulse and re-arms the adder. It sits between the requester ports and the single bit-serial adder, which it owns exclusively.

---
 rtl/add_serial_sched.sv | 168 ++++++++++++++++
 tb/tb_add_serial_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/add_serial_sched.sv
// Round-robin / fixed-priority scheduler sharing one bit-serial adder among NREQ requesters.
// Define ADD_SERIAL_SCHED_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module add_serial_sched #(
   parameter int NREQ    = 4,
   parameter int W       = 8,
   parameter int ADD_LAT = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] a_in,
   input  logic [NREQ*W-1:0] b_in,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   done,
   output logic [W-1:0]      result,
   output logic              add_en,
   output logic [W-1:0]      add_a,
   output logic [W-1:0]      add_b,
   input  logic [W-1:0]      add_out
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = ($clog2(ADD_LAT) > 0) ? $clog2(ADD_LAT) : 1;

   // Handshake: a requester raises req[i] with valid operands and holds it until
   // done[i]; the grant edge is the only point where operands are sampled.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_WAIT    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   win_q, win_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] done_q, done_d;
   logic [W-1:0]    result_q, result_d;
   logic            add_en_q, add_en_d;
   logic [W-1:0]    add_a_q, add_a_d;
   logic [W-1:0]    add_b_q, add_b_d;

   logic            req_any;
   logic [IW-1:0]   pick;

`ifdef ADD_SERIAL_SCHED_RR_EN
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   int unsigned     arb_t;
   logic [IW-1:0]   arb_cand;

   // Scan downwards so the candidate closest to rr_ptr overwrites the others.
   always_comb begin
      pick     = '0;
      req_any  = 1'b0;
      arb_t    = 0;
      arb_cand = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         arb_t = int'(rr_ptr_q) + k;
         if (arb_t >= NREQ) arb_t = arb_t - NREQ;
         arb_cand = IW'(arb_t);
         if (req[arb_cand]) begin
            pick    = arb_cand;
            req_any = 1'b1;
         end
      end
   end
`else
   always_comb begin
      pick    = '0;
      req_any = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req[k]) begin
            pick    = IW'(k);
            req_any = 1'b1;
         end
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      win_d    = win_q;
      gnt_d    = gnt_q;
      done_d   = '0;
      result_d = result_q;
      add_en_d = 1'b0;
      add_a_d  = add_a_q;
      add_b_d  = add_b_q;
`ifdef ADD_SERIAL_SCHED_RR_EN
      rr_ptr_d = rr_ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               win_d    = pick;
               gnt_d    = {{(NREQ-1){1'b0}}, 1'b1} << pick;
               add_a_d  = a_in[pick*W +: W];
               add_b_d  = b_in[pick*W +: W];
               add_en_d = 1'b1;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cnt_q == CW'(ADD_LAT - 1)) begin
               result_d = add_out;
               done_d   = {{(NREQ-1){1'b0}}, 1'b1} << win_q;
               // Release pulse: returns the adder from DONE to IDLE.
               add_en_d = 1'b1;
               state_d  = ST_RELEASE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RELEASE: begin
            gnt_d   = '0;
`ifdef ADD_SERIAL_SCHED_RR_EN
            rr_ptr_d = (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
`endif
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         win_q    <= '0;
         gnt_q    <= '0;
         done_q   <= '0;
         result_q <= '0;
         add_en_q <= 1'b0;
         add_a_q  <= '0;
         add_b_q  <= '0;
`ifdef ADD_SERIAL_SCHED_RR_EN
         rr_ptr_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         win_q    <= win_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         result_q <= result_d;
         add_en_q <= add_en_d;
         add_a_q  <= add_a_d;
         add_b_q  <= add_b_d;
`ifdef ADD_SERIAL_SCHED_RR_EN
         rr_ptr_q <= rr_ptr_d;
`endif
      end
   end

   assign gnt    = gnt_q;
   assign done   = done_q;
   assign result = result_q;
   assign add_en = add_en_q;
   assign add_a  = add_a_q;
   assign add_b  = add_b_q;

endmodule

// File: tb/tb_add_serial_sched.sv
// Directed bench for add_serial_sched with a timing-accurate stand-in for the bit-serial adder.
// Expected grant order follows ADD_SERIAL_SCHED_RR_EN when it is defined at compile time.
module tb_add_serial_sched;

   localparam int NREQ = 4;
   localparam int W    = 8;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*W-1:0] a_in;
   logic [NREQ*W-1:0] b_in;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic [W-1:0]      result;
   logic              add_en;
   logic [W-1:0]      add_a;
   logic [W-1:0]      add_b;
   logic [W-1:0]      add_out;

   int n_vec = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];

   add_serial_sched #(.NREQ(NREQ), .W(W), .ADD_LAT(10)) dut (
      .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
      .gnt(gnt), .done(done), .result(result), .add_en(add_en),
      .add_a(add_a), .add_b(add_b), .add_out(add_out)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- adder stand-in ----------------
   // Samples en=1 while idle, result valid 9 edges later, released by the next en.
   logic         m_busy;
   int           m_cnt;
   logic [W-1:0] m_sum;
   int           proto_err;
   int           en_viol;
   logic         prev_en;

   function automatic logic [W-1:0] exp_sum(input logic [W-1:0] a, input logic [W-1:0] b);
      return (a ^ 8'h3E) + (b ^ 8'hA4);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_cnt  <= 0;
         m_sum  <= '0;
      end else if (add_en && !m_busy) begin
         m_busy <= 1'b1;
         m_cnt  <= 0;
         m_sum  <= exp_sum(add_a, add_b);
      end else if (m_busy) begin
         if (add_en && m_cnt >= 9) m_busy <= 1'b0;
         else begin
            if (add_en) proto_err <= proto_err + 1;
            m_cnt <= m_cnt + 1;
         end
      end
   end

   assign add_out = (m_busy && m_cnt >= 9) ? m_sum : 8'h5A;

   always @(negedge clk) begin
      if (!rst && add_en && prev_en) en_viol = en_viol + 1;
      prev_en = add_en;
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int onehot_idx(input logic [NREQ-1:0] g);
      int idx = -1;
      int n   = 0;
      for (int i = 0; i < NREQ; i++) if (g[i]) begin idx = i; n++; end
      return (n == 1) ? idx : -1;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic wait_grant(output int idx, output int waited);
      idx    = -1;
      waited = 0;
      while (waited < 60) begin
         @(negedge clk);
         waited++;
         if (gnt !== '0) break;
      end
      if (gnt === '0) check("grant_timeout", 1, 0);
      else idx = onehot_idx(gnt);
   endtask

   // Entered at the negedge just after the grant edge E; leaves at the negedge after E+12.
   task automatic finish_txn(input string tag, input int idx, input logic [W-1:0] ea,
                             input logic [W-1:0] eb, input bit chg, input bit hold);
      logic [NREQ-1:0] oh;
      logic [W-1:0]    exp_r;
      oh = 4'b0001 << idx;
      exp_q.push_back(exp_sum(ea, eb));
      check({tag, "_gnt"}, gnt, oh);
      check({tag, "_en_issue"}, add_en, 1);
      check({tag, "_add_a"}, add_a, ea);
      check({tag, "_add_b"}, add_b, eb);
      @(negedge clk);
      if (chg) begin
         a_in[idx*W +: W] = 8'hFF;
         b_in[idx*W +: W] = 8'hFF;
      end
      check({tag, "_en_low"}, add_en, 0);
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         check({tag, "_done_early"}, done, 0);
         check({tag, "_en_wait"}, add_en, 0);
      end
      @(negedge clk);
      exp_r = exp_q.pop_front();
      check({tag, "_done"}, done, oh);
      check({tag, "_result"}, result, exp_r);
      check({tag, "_en_release"}, add_en, 1);
      check({tag, "_add_a_held"}, add_a, ea);
      check({tag, "_add_b_held"}, add_b, eb);
      check({tag, "_gnt_held"}, gnt, oh);
      if (!hold) req[idx] = 1'b0;
      @(negedge clk);
      check({tag, "_gnt_drop"}, gnt, 0);
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_en_after"}, add_en, 0);
      check({tag, "_result_stable"}, result, exp_r);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- stimulus ----------------
   int idx, waited;
   int exp_order[5];

   initial begin
      rst = 1'b1; req = '0; a_in = '0; b_in = '0;
      proto_err = 0; en_viol = 0; prev_en = 1'b0;
`ifdef ADD_SERIAL_SCHED_RR_EN
      exp_order = '{0, 1, 2, 3, 0};
`else
      exp_order = '{0, 0, 0, 0, 0};
`endif
      repeat (2) @(negedge clk);
      check("rst_gnt", gnt, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 0);
      check("rst_add_en", add_en, 0);
      check("rst_add_a", add_a, 0);
      check("rst_add_b", add_b, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_no_en", add_en, 0);

      // Single request from requester 0 with zero operands.
      req = 4'b0001;
      wait_grant(idx, waited);
      check("t1_idx", idx, 0);
      check("t1_latency", waited, 1);
      if (idx >= 0) finish_txn("t1", idx, 8'h00, 8'h00, 1'b0, 1'b0);
      @(negedge clk);
      check("t1_idle_en", add_en, 0);

      // Requesters 1 and 2 together.
      a_in[1*W +: W] = 8'h05; b_in[1*W +: W] = 8'h09;
      a_in[2*W +: W] = 8'hC3; b_in[2*W +: W] = 8'h7E;
      req = 4'b0110;
      wait_grant(idx, waited);
      check("t2_first", idx, 1);
      if (idx >= 0) finish_txn("t2a", idx, a_in[idx*W +: W], b_in[idx*W +: W], 1'b0, 1'b0);
      wait_grant(idx, waited);
      check("t2_second", idx, 2);
      check("t2_gap", waited, 1);
      if (idx >= 0) finish_txn("t2b", idx, a_in[idx*W +: W], b_in[idx*W +: W], 1'b0, 1'b0);

      // All four held continuously, arbitration from a fresh pointer.
      do_reset();
      for (int i = 0; i < NREQ; i++) begin
         a_in[i*W +: W] = 8'(8'h11 * i);
         b_in[i*W +: W] = 8'(8'h20 + i);
      end
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         wait_grant(idx, waited);
         check("t3_order", idx, exp_order[t]);
         if (t > 0) check("t3_gap", waited, 1);
         if (idx >= 0) finish_txn("t3", idx, a_in[idx*W +: W], b_in[idx*W +: W], 1'b0, 1'b1);
      end
      req = '0;
      repeat (2) @(negedge clk);

      // Operands change one cycle after the grant.
      a_in[3*W +: W] = 8'h00; b_in[3*W +: W] = 8'h00;
      req = 4'b1000;
      wait_grant(idx, waited);
      check("t4_idx", idx, 3);
      if (idx >= 0) finish_txn("t4", idx, 8'h00, 8'h00, 1'b1, 1'b0);

      // Reset while waiting at cnt=5.
      a_in[0*W +: W] = 8'h12; b_in[0*W +: W] = 8'h34;
      req = 4'b0001;
      wait_grant(idx, waited);
      check("t5_idx", idx, 0);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      req = '0;
      #1;
      check("t5_rst_gnt", gnt, 0);
      check("t5_rst_done", done, 0);
      check("t5_rst_result", result, 0);
      check("t5_rst_add_en", add_en, 0);
      check("t5_rst_add_a", add_a, 0);
      check("t5_rst_add_b", add_b, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         check("t5_no_done", done, 0);
      end
      a_in[1*W +: W] = 8'h12; b_in[1*W +: W] = 8'h34;
      req = 4'b0010;
      wait_grant(idx, waited);
      check("t5_fresh_idx", idx, 1);
      if (idx >= 0) finish_txn("t5", idx, 8'h12, 8'h34, 1'b0, 1'b0);
      check("t5_exp_sum", result, 8'hBC);

      repeat (3) @(negedge clk);
      check("proto_en_early", proto_err, 0);
      check("en_back_to_back", en_viol, 0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
